// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, accumulator-load, ALU and FSM state encodings for the accumulator CPU.
package cpu_pkg;
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_STA = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_JMP = 3'd6;
    localparam logic [2:0] OP_JZ  = 3'd7;
    localparam logic [1:0] AC_HOLD = 2'd0;
    localparam logic [1:0] AC_ALU  = 2'd1;
    localparam logic [1:0] AC_MEM  = 2'd2;
    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_AND  = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;
    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT} state_t;
endpackage

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: three-cycle fetch/decode/execute control FSM for the 8-bit accumulator CPU.
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int OPC_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        mem_data,
    input  logic              ac_zero,
    output logic [ADDR_W-1:0] op_addr,
    output logic              addr_sel,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [1:0]        ac_en,
    output logic [1:0]        alu_op,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_cnt
);
    state_t state, state_nx;
    logic [7:0] ir;
    logic [OPC_W-1:0] opc;
    assign opc = ir[7 -: OPC_W];
    assign op_addr = ir[ADDR_W-1:0];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ir        <= '0;
            instr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_FETCH)
                ir <= mem_data;
            // HLT retires on its way into HALT; every other opcode retires leaving EXEC
            if (state == ST_EXEC || (state == ST_DECODE && opc == OP_HLT))
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
    always_comb begin
        state_nx = state;
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        ac_en    = AC_HOLD;
        alu_op   = ALU_ADD;
        halted   = 1'b0;
        case (state)
            ST_IDLE:   state_nx = start ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                mem_rd   = 1'b1;
                state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                pc_inc   = 1'b1;
                state_nx = (opc == OP_HLT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                addr_sel = 1'b1;
                alu_op   = ALU_PASS;
                state_nx = ST_FETCH;
                case (opc)
                    OP_LDA: begin mem_rd = 1'b1; ac_en = AC_MEM; end
                    OP_STA: mem_wr = 1'b1;
                    OP_ADD: begin mem_rd = 1'b1; ac_en = AC_ALU; alu_op = ALU_ADD; end
                    OP_SUB: begin mem_rd = 1'b1; ac_en = AC_ALU; alu_op = ALU_SUB; end
                    OP_AND: begin mem_rd = 1'b1; ac_en = AC_ALU; alu_op = ALU_AND; end
                    OP_JMP: pc_load = 1'b1;
                    OP_JZ:  pc_load = ac_zero;
                    default: ;
                endcase
            end
            ST_HALT:   halted = 1'b1;
            default:   state_nx = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: random and directed instruction streams checked against a phase-counting model.
module tb_cpu_ctrl_seq;
    logic clk = 0, rst = 0, start = 0, ac_zero = 0;
    logic [7:0] mem_data = 0;
    logic [4:0] op_addr, w_op_addr;
    logic addr_sel, mem_rd, mem_wr, pc_inc, pc_load, halted;
    logic w_addr_sel, w_mem_rd, w_mem_wr, w_pc_inc, w_pc_load, w_halted;
    logic [1:0] ac_en, alu_op, w_ac_en, w_alu_op;
    logic [15:0] instr_cnt;
    logic [3:0] w_instr_cnt;

    cpu_ctrl_seq dut (.clk(clk), .rst(rst), .start(start), .mem_data(mem_data), .ac_zero(ac_zero),
        .op_addr(op_addr), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .pc_inc(pc_inc),
        .pc_load(pc_load), .ac_en(ac_en), .alu_op(alu_op), .halted(halted), .instr_cnt(instr_cnt));
    cpu_ctrl_seq #(.CNT_W(4)) dut_w (.clk(clk), .rst(rst), .start(start), .mem_data(mem_data),
        .ac_zero(ac_zero), .op_addr(w_op_addr), .addr_sel(w_addr_sel), .mem_rd(w_mem_rd),
        .mem_wr(w_mem_wr), .pc_inc(w_pc_inc), .pc_load(w_pc_load), .ac_en(w_ac_en),
        .alu_op(w_alu_op), .halted(w_halted), .instr_cnt(w_instr_cnt));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    // Model: running flag, position within the 3-cycle instruction, halted flag, IR, retired count
    bit m_act, m_halt;
    int m_pos, m_cnt;
    logic [7:0] m_ir;
    // Per-opcode execute-cycle effects, indexed by opcode
    int t_rd  [8] = '{0, 1, 0, 1, 1, 1, 0, 0};
    int t_wr  [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    int t_ac  [8] = '{0, 2, 0, 1, 1, 1, 0, 0};
    int t_alu [8] = '{3, 3, 3, 0, 1, 2, 3, 3};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_halt = 0; m_pos = 0; m_cnt = 0; m_ir = 0;
    endtask

    task automatic model_step();
        if (m_halt) return;
        if (!m_act) begin
            if (start) begin m_act = 1; m_pos = 0; end
        end else if (m_pos == 0) begin
            m_ir = mem_data; m_pos = 1;
        end else if (m_pos == 1) begin
            if (m_ir[7:5] == 3'd0) begin m_halt = 1; m_cnt++; end
            else m_pos = 2;
        end else begin
            m_cnt++; m_pos = 0;
        end
    endtask

    task automatic check_model();
        int op, e_sel, e_rd, e_wr, e_inc, e_ld, e_ac, e_alu, e_h;
        op = int'(m_ir[7:5]);
        e_sel = 0; e_rd = 0; e_wr = 0; e_inc = 0; e_ld = 0; e_ac = 0; e_alu = 0; e_h = 0;
        if (m_halt) e_h = 1;
        else if (m_act && m_pos == 0) e_rd = 1;
        else if (m_act && m_pos == 1) e_inc = 1;
        else if (m_act) begin
            e_sel = 1; e_rd = t_rd[op]; e_wr = t_wr[op]; e_ac = t_ac[op]; e_alu = t_alu[op];
            e_ld = (op == 6) ? 1 : (op == 7) ? int'(ac_zero) : 0;
        end
        chk("addr_sel", 32'(addr_sel), 32'(e_sel));
        chk("mem_rd", 32'(mem_rd), 32'(e_rd));
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        chk("pc_inc", 32'(pc_inc), 32'(e_inc));
        chk("pc_load", 32'(pc_load), 32'(e_ld));
        chk("ac_en", 32'(ac_en), 32'(e_ac));
        chk("alu_op", 32'(alu_op), 32'(e_alu));
        chk("halted", 32'(halted), 32'(e_h));
        chk("op_addr", 32'(op_addr), 32'(m_ir[4:0]));
        chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt % 65536));
        chk("instr_cnt_w4", 32'(w_instr_cnt), 32'(m_cnt % 16));
        chk("rd_and_wr", 32'(mem_rd & mem_wr), 0);
        chk("inc_and_load", 32'(pc_inc & pc_load), 0);
    endtask

    // One clock: drive at negedge, check mid-low phase, advance the model at posedge
    task automatic cyc(input logic r, input logic s, input logic [7:0] md, input logic z);
        @(negedge clk);
        rst = r; start = s; mem_data = md; ac_zero = z;
        #1;
        if (!r) model_reset();
        check_model();
        @(posedge clk);
        if (r) model_step();
        #1;
    endtask

    initial begin
        logic [7:0] b;
        model_reset();
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // LDA 5
        cyc(1, 1, 8'h00, 0);
        cyc(1, 0, 8'h25, 0);
        chk("lda_decode_pc_inc", 32'(pc_inc), 1);
        cyc(1, 0, 8'h00, 0);
        chk("lda_ac_en", 32'(ac_en), 2);
        chk("lda_op_addr", 32'(op_addr), 5);
        chk("lda_rd_sel", {30'd0, mem_rd, addr_sel}, 3);
        cyc(1, 0, 8'h00, 0);
        chk("lda_cnt", 32'(instr_cnt), 1);
        // ADD 0x1F then SUB 0x01
        cyc(1, 0, 8'h7F, 0); cyc(1, 0, 8'h00, 0);
        chk("add_ac_alu", {28'd0, ac_en, alu_op}, 32'h4);
        chk("add_op_addr", 32'(op_addr), 32'h1F);
        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h81, 0); cyc(1, 0, 8'h00, 0);
        chk("sub_ac_alu", {28'd0, ac_en, alu_op}, 32'h5);
        cyc(1, 0, 8'h00, 0);
        chk("sub_cnt", 32'(instr_cnt), 3);
        // JZ taken then not taken
        cyc(1, 0, 8'hE3, 1); cyc(1, 0, 8'h00, 1);
        chk("jz_taken", 32'(pc_load), 1);
        cyc(1, 0, 8'h00, 1);
        cyc(1, 0, 8'hE3, 0);
        chk("jz_decode_inc", 32'(pc_inc), 1);
        cyc(1, 0, 8'h00, 0);
        chk("jz_not_taken", 32'(pc_load), 0);
        cyc(1, 0, 8'h00, 0);
        // STA 0x0A
        cyc(1, 0, 8'h4A, 0); cyc(1, 0, 8'h00, 0);
        chk("sta_wr_rd_ac", {28'd0, mem_wr, mem_rd, ac_en}, 32'h8);
        chk("sta_op_addr", 32'(op_addr), 32'h0A);
        cyc(1, 0, 8'h00, 0);
        chk("sta_cnt", 32'(instr_cnt), 6);
        // ADD interrupted by reset in its execute cycle
        cyc(1, 0, 8'h7F, 0); cyc(1, 0, 8'h00, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_outputs", {20'd0, addr_sel, mem_rd, mem_wr, pc_inc, pc_load, ac_en, alu_op, halted},
            0);
        chk("rst_cnt", 32'(instr_cnt), 0);
        model_reset();
        @(posedge clk); #1;
        cyc(1, 0, 0, 0);
        // HLT, then start pulses must be ignored
        cyc(1, 1, 8'h00, 0); cyc(1, 0, 8'h00, 0); cyc(1, 0, 8'h00, 0);
        chk("hlt_halted", 32'(halted), 1);
        chk("hlt_cnt", 32'(instr_cnt), 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 8'h25, 0);
        chk("hlt_stays", {30'd0, halted, mem_rd}, 2);
        chk("hlt_cnt_still", 32'(instr_cnt), 1);
        // 16 instructions wrap the 4-bit counter
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 8'h20 | 8'(i), 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        end
        chk("wrap_cnt4", 32'(w_instr_cnt), 0);
        chk("wrap_cnt16", 32'(instr_cnt), 16);
        // Random streams with occasional resets; HLT is kept rare
        for (int i = 0; i < 4000; i++) begin
            b = 8'($urandom);
            if (b[7:5] == 3'd0 && $urandom_range(0, 9) != 0) b[7:5] = 3'(1 + $urandom_range(0, 6));
            cyc((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0 ? 1'b0 : 1'b1,
                1'($urandom_range(0, 3) != 0), b, 1'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
